// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings, default width, clog2.
package uart_pkg;

   localparam int unsigned DBIT_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_WAIT  = 2'b10
   } state_t;

   // Ceiling log2, never below 1 so single-bit indices stay legal.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          valid
);

   // Scan offsets high to low so the smallest offset from ptr wins.
   always_comb begin
      int idx;
      grant = '0;
      valid = |req;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % int'(N);
         if (req[idx]) grant = IW'(idx);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte producers.
// Optional watchdog abort enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DBIT           = DBIT_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [NUM_REQ-1:0]       i_req,
   input  logic [NUM_REQ*DBIT-1:0]  i_data,
   input  logic                     i_tx_done_tick,
   output logic                     o_tx_start,
   output logic [DBIT-1:0]          o_tx_din,
   output logic [NUM_REQ-1:0]       o_ack,
   output logic [clog2(NUM_REQ)-1:0] o_grant_id,
   output logic                     o_busy,
   output logic                     o_timeout
);

   localparam int unsigned IW = clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
   end

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   arb_grant;
   logic            arb_valid;
   logic [DBIT-1:0] sel_data;
   logic [IW-1:0]   next_ptr;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
      .req   (i_req),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   // Byte of the requester the arbiter is currently picking.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (arb_grant == IW'(k)) sel_data = i_data[k*DBIT +: DBIT];
      end
   end

   assign next_ptr = (o_grant_id == IW'(NUM_REQ - 1)) ? '0 : o_grant_id + IW'(1);

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned WW = clog2(TIMEOUT_CYCLES);
   logic [WW-1:0] wdog;
`else
   assign o_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         o_tx_start <= 1'b0;
         o_tx_din   <= '0;
         o_ack      <= '0;
         o_grant_id <= '0;
         o_busy     <= 1'b0;
         rr_ptr     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         o_timeout  <= 1'b0;
         wdog       <= '0;
`endif
      end else begin
         o_tx_start <= 1'b0;
         o_ack      <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         o_timeout  <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  o_grant_id <= arb_grant;
                  o_tx_din   <= sel_data;
                  o_tx_start <= 1'b1;
                  o_busy     <= 1'b1;
                  state      <= ST_START;
               end
            end
            ST_START: begin
               state <= ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
               wdog  <= '0;
`endif
            end
            ST_WAIT: begin
               if (i_tx_done_tick) begin
                  o_ack[o_grant_id] <= 1'b1;
                  rr_ptr            <= next_ptr;
                  o_busy            <= 1'b0;
                  state             <= ST_IDLE;
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
                  o_timeout <= 1'b1;
                  rr_ptr    <= next_ptr;
                  o_busy    <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  wdog <= wdog + WW'(1);
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, DBIT=8, TIMEOUT_CYCLES=16).
module tb_uart_tx_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [3:0]  i_req;
   logic [31:0] i_data;
   logic        i_tx_done_tick;
   logic        o_tx_start;
   logic [7:0]  o_tx_din;
   logic [3:0]  o_ack;
   logic [1:0]  o_grant_id;
   logic        o_busy;
   logic        o_timeout;

   int errors = 0;
   int checks = 0;

   uart_tx_arbiter #(.NUM_REQ(4), .DBIT(8), .TIMEOUT_CYCLES(16)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_req          (i_req),
      .i_data         (i_data),
      .i_tx_done_tick (i_tx_done_tick),
      .o_tx_start     (o_tx_start),
      .o_tx_din       (o_tx_din),
      .o_ack          (o_ack),
      .o_grant_id     (o_grant_id),
      .o_busy         (o_busy),
      .o_timeout      (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
   endtask

   // Called in an IDLE cycle with requests present; returns in the ack cycle.
   task automatic xfer(input string tag, input logic [1:0] id, input logic [7:0] b);
      tick();
      chk({tag, " start"}, 32'(o_tx_start), 32'd1);
      chk({tag, " din"}, 32'(o_tx_din), 32'(b));
      chk({tag, " grant"}, 32'(o_grant_id), 32'(id));
      chk({tag, " busy"}, 32'(o_busy), 32'd1);
      chk({tag, " ack_clear"}, 32'(o_ack), 32'd0);
      tick();
      chk({tag, " start_1cyc"}, 32'(o_tx_start), 32'd0);
      chk({tag, " busy_wait"}, 32'(o_busy), 32'd1);
      i_tx_done_tick = 1'b1;
      tick();
      i_tx_done_tick = 1'b0;
      chk({tag, " ack"}, 32'(o_ack), 32'(4'b0001 << id));
      chk({tag, " busy_off"}, 32'(o_busy), 32'd0);
      chk({tag, " timeout"}, 32'(o_timeout), 32'd0);
   endtask

   initial begin
      i_reset        = 1'b1;
      i_req          = 4'b0000;
      i_data         = 32'h13121110;
      i_tx_done_tick = 1'b0;
      #1;
      chk("rst start", 32'(o_tx_start), 32'd0);
      chk("rst din", 32'(o_tx_din), 32'd0);
      chk("rst ack", 32'(o_ack), 32'd0);
      chk("rst grant", 32'(o_grant_id), 32'd0);
      chk("rst busy", 32'(o_busy), 32'd0);
      chk("rst timeout", 32'(o_timeout), 32'd0);
      tick();
      i_reset = 1'b0;
      tick();

      // Single request on slot 2.
      i_data = 32'h00A50000;
      i_req  = 4'b0100;
      xfer("single", 2'd2, 8'hA5);
      i_req = 4'b0000;
      tick();
      chk("single ack_1cyc", 32'(o_ack), 32'd0);
      chk("single idle", 32'(o_tx_start), 32'd0);

      // All requesting from a fresh pointer.
      do_reset();
      i_data = 32'h13121110;
      i_req  = 4'b1111;
      xfer("all0", 2'd0, 8'h10);
      xfer("all1", 2'd1, 8'h11);
      xfer("all2", 2'd2, 8'h12);
      xfer("all3", 2'd3, 8'h13);
      xfer("all4", 2'd0, 8'h10);

      // Pointer now at 1: slot 1 first, then slot 0 even with 1 still requesting.
      i_req = 4'b0011;
      xfer("rot1", 2'd1, 8'h11);
      xfer("rot0", 2'd0, 8'h10);
      i_req = 4'b0000;
      tick();

      // Byte captured at grant; done tick during START ignored.
      do_reset();
      i_data = 32'h0000003C;
      i_req  = 4'b0001;
      tick();
      chk("cap start", 32'(o_tx_start), 32'd1);
      i_data         = 32'h000000FF;
      i_tx_done_tick = 1'b1;
      tick();
      i_tx_done_tick = 1'b0;
      chk("cap din_wait", 32'(o_tx_din), 32'h3C);
      chk("cap start_done_ign", 32'(o_ack), 32'd0);
      tick();
      chk("cap still_busy", 32'(o_busy), 32'd1);
      chk("cap din_hold", 32'(o_tx_din), 32'h3C);
      i_req          = 4'b0000;
      i_tx_done_tick = 1'b1;
      tick();
      i_tx_done_tick = 1'b0;
      chk("cap ack_after_drop", 32'(o_ack), 32'd1);
      chk("cap din_final", 32'(o_tx_din), 32'h3C);
      i_tx_done_tick = 1'b1;
      tick();
      i_tx_done_tick = 1'b0;
      chk("stray ack", 32'(o_ack), 32'd0);
      chk("stray busy", 32'(o_busy), 32'd0);
      chk("stray start", 32'(o_tx_start), 32'd0);

      // Reset while waiting on slot 2.
      i_data = 32'h00770000;
      i_req  = 4'b0100;
      tick();
      tick();
      chk("mid busy", 32'(o_busy), 32'd1);
      chk("mid grant", 32'(o_grant_id), 32'd2);
      i_reset = 1'b1;
      #1;
      chk("mid rst busy", 32'(o_busy), 32'd0);
      chk("mid rst grant", 32'(o_grant_id), 32'd0);
      chk("mid rst din", 32'(o_tx_din), 32'd0);
      chk("mid rst ack", 32'(o_ack), 32'd0);
      tick();
      i_reset = 1'b0;
      i_data  = 32'h000000C3;
      i_req   = 4'b0001;
      xfer("post_rst", 2'd0, 8'hC3);
      i_req = 4'b0000;
      tick();

`ifdef UART_ARB_TIMEOUT_EN
      // Watchdog: no done tick, abort 16 cycles into WAIT, then next requester.
      do_reset();
      i_data = 32'h0000BBAA;
      i_req  = 4'b0011;
      tick();
      chk("wd start", 32'(o_tx_start), 32'd1);
      for (int c = 0; c < 16; c++) begin
         tick();
         chk("wd no_timeout", 32'(o_timeout), 32'd0);
      end
      tick();
      chk("wd timeout", 32'(o_timeout), 32'd1);
      chk("wd no_ack", 32'(o_ack), 32'd0);
      chk("wd busy_off", 32'(o_busy), 32'd0);
      tick();
      chk("wd timeout_1cyc", 32'(o_timeout), 32'd0);
      chk("wd next_start", 32'(o_tx_start), 32'd1);
      chk("wd next_grant", 32'(o_grant_id), 32'd1);
      chk("wd next_din", 32'(o_tx_din), 32'hBB);
      i_req = 4'b0000;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
